// File: rtl/rom_dl_pkg.sv
// rom_dl_pkg: shared types for the ROM download bridge.
//   dl_word_t  - one buffered SDRAM write {word address, byte enables, data}
//   dl_state_t - download sequencing states
//   place_byte - steers a download byte into its little-endian lane
//   merge_byte - folds a newly placed byte into a held partial word
package rom_dl_pkg;

  typedef struct packed {
    logic [22:0] a;
    logic [1:0]  ds;
    logic [15:0] d;
  } dl_word_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    FLUSH = 2'd2,
    DONE  = 2'd3
  } dl_state_t;

  // Even byte address -> low lane (ds[0]); odd byte address -> high lane (ds[1]).
  function automatic dl_word_t place_byte(input logic [23:0] addr, input logic [7:0] data);
    dl_word_t w;
    w.a = addr[23:1];
    if (addr[0]) begin
      w.ds = 2'b10;
      w.d  = {data, 8'h00};
    end else begin
      w.ds = 2'b01;
      w.d  = {8'h00, data};
    end
    return w;
  endfunction

  // The new byte overwrites only its own lane; the held lane is preserved.
  function automatic dl_word_t merge_byte(input dl_word_t held, input dl_word_t nb);
    dl_word_t    m;
    logic [15:0] lane;
    lane = {{8{nb.ds[1]}}, {8{nb.ds[0]}}};
    m.a  = held.a;
    m.ds = held.ds | nb.ds;
    m.d  = (held.d & ~lane) | nb.d;
    return m;
  endfunction

endpackage

// File: rtl/rom_dl_bridge_fifo.sv
// dl_word_fifo: small synchronous FIFO of dl_word_t entries.
// Ports:
//   i_clk, i_reset      - clock, asynchronous active-high reset
//   i_push, i_wdata     - write request and entry (ignored when full)
//   i_pop               - read request (ignored when empty)
//   o_rdata             - head entry (valid when not empty)
//   o_full, o_empty     - status
//   o_count             - occupancy, 0..FIFO_DEPTH
// Pointers carry one extra wrap bit so full and empty are distinguishable.
module dl_word_fifo
  import rom_dl_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                         i_clk,
  input  logic                         i_reset,
  input  logic                         i_push,
  input  dl_word_t                     i_wdata,
  input  logic                         i_pop,
  output dl_word_t                     o_rdata,
  output logic                         o_full,
  output logic                         o_empty,
  output logic [$clog2(FIFO_DEPTH):0]  o_count
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);

  dl_word_t    r_mem [FIFO_DEPTH];
  logic [AW:0] r_wptr;
  logic [AW:0] r_rptr;
  logic        w_do_push;
  logic        w_do_pop;

  assign o_full    = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
  assign o_empty   = (r_wptr == r_rptr);
  assign o_count   = r_wptr - r_rptr;
  assign o_rdata   = r_mem[r_rptr[AW-1:0]];
  assign w_do_push = i_push && !o_full;
  assign w_do_pop  = i_pop && !o_empty;

  // Storage and pointer update; simultaneous push and pop both advance.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_wptr <= '0;
      r_rptr <= '0;
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else begin
      if (w_do_push) begin
        r_mem[r_wptr[AW-1:0]] <= i_wdata;
        r_wptr                <= r_wptr + {{AW{1'b0}}, 1'b1};
      end
      if (w_do_pop) begin
        r_rptr <= r_rptr + {{AW{1'b0}}, 1'b1};
      end
    end
  end

endmodule

// File: rtl/rom_dl_bridge.sv
// rom_dl_bridge: packs the byte-wide ROM download stream into 16-bit masked
// writes and issues them on a toggle-handshake SDRAM controller port.
// Ports:
//   i_clk, i_reset                 - SDRAM clock, asynchronous active-high reset
//   i_dl_active, i_dl_wr           - download window and one-cycle byte strobe
//   i_dl_addr[23:0], i_dl_data[7:0]- byte address and data
//   o_dl_wait                      - backpressure to the downloader
//   o_port_req / i_port_ack        - request / acknowledge toggles
//   o_port_we                      - always 1 (write-only port)
//   o_port_a[22:0], o_port_ds[1:0], o_port_d[15:0] - registered request payload
//   o_dl_done                      - one-cycle pulse once everything is committed
//   o_dl_ovf                       - sticky: a byte was dropped on a full FIFO
// The controller's port state must be reset together with this block so that
// req == ack means "idle" on both sides.
module rom_dl_bridge
  import rom_dl_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_dl_active,
  input  logic        i_dl_wr,
  input  logic [23:0] i_dl_addr,
  input  logic [7:0]  i_dl_data,
  output logic        o_dl_wait,
  output logic        o_port_req,
  input  logic        i_port_ack,
  output logic        o_port_we,
  output logic [22:0] o_port_a,
  output logic [1:0]  o_port_ds,
  output logic [15:0] o_port_d,
  output logic        o_dl_done,
  output logic        o_dl_ovf
);

  localparam int unsigned AW       = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] WAIT_LVL = (AW+1)'(FIFO_DEPTH - 1);

  // Registers
  dl_state_t   r_state;
  dl_word_t    r_pk;
  logic        r_pk_valid;
  logic        r_act_q;
  logic        r_rise_pend;
  logic        r_port_req;
  logic [22:0] r_port_a;
  logic [1:0]  r_port_ds;
  logic [15:0] r_port_d;
  logic        r_dl_wait;
  logic        r_dl_done;
  logic        r_dl_ovf;

  // Wires
  dl_word_t    w_new;
  dl_word_t    w_push_word;
  dl_word_t    w_head;
  logic        w_strobe;
  logic        w_same;
  logic        w_push;
  logic        w_drop;
  logic        w_pk_load;
  logic        w_pk_clear;
  logic        w_full;
  logic        w_empty;
  logic [AW:0] w_count;
  logic        w_port_idle;
  logic        w_issue;
  logic        w_act_rise;

  assign w_new       = place_byte(i_dl_addr, i_dl_data);
  assign w_strobe    = (r_state == LOAD) && i_dl_active && i_dl_wr;
  assign w_same      = r_pk_valid && (r_pk.a == w_new.a);
  assign w_act_rise  = i_dl_active && !r_act_q;
  // Ack is compared combinationally so the next request can go out on the
  // same edge that sees the acknowledge.
  assign w_port_idle = (r_port_req == i_port_ack);
  assign w_issue     = w_port_idle && !w_empty;

  // Packer decision: what (if anything) is pushed this cycle and how the
  // packing register changes.
  always_comb begin
    w_push      = 1'b0;
    w_push_word = r_pk;
    w_drop      = 1'b0;
    w_pk_load   = 1'b0;
    w_pk_clear  = 1'b0;
    if (w_strobe) begin
      if (w_same) begin
        // Completing byte: a full FIFO drops it and keeps the held partial.
        if (!w_full) begin
          w_push      = 1'b1;
          w_push_word = merge_byte(r_pk, w_new);
          w_pk_clear  = 1'b1;
        end else begin
          w_drop = 1'b1;
        end
      end else if (r_pk_valid) begin
        // Different word: evict the held partial to make room for the new byte.
        if (!w_full) begin
          w_push    = 1'b1;
          w_pk_load = 1'b1;
        end else begin
          w_drop = 1'b1;
        end
      end else begin
        w_pk_load = 1'b1;
      end
    end else if ((r_state == FLUSH) && r_pk_valid) begin
      // Trailing partial word; retried every cycle until the FIFO has room.
      if (!w_full) begin
        w_push     = 1'b1;
        w_pk_clear = 1'b1;
      end else begin
        w_push = 1'b0;
      end
    end else begin
      w_push = 1'b0;
    end
  end

  dl_word_fifo #(
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_push  (w_push),
    .i_wdata (w_push_word),
    .i_pop   (w_issue),
    .o_rdata (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  // Download sequencing FSM together with the packing register and the
  // done/overflow flags it owns.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state     <= IDLE;
      r_pk        <= '0;
      r_pk_valid  <= 1'b0;
      r_act_q     <= 1'b0;
      r_rise_pend <= 1'b0;
      r_dl_done   <= 1'b0;
      r_dl_ovf    <= 1'b0;
    end else begin
      r_act_q   <= i_dl_active;
      r_dl_done <= 1'b0;
      case (r_state)
        IDLE: begin
          // A rise seen during FLUSH/DONE is honoured here if still active.
          if (w_act_rise || (r_rise_pend && i_dl_active)) begin
            r_state     <= LOAD;
            r_pk        <= '0;
            r_pk_valid  <= 1'b0;
            r_dl_ovf    <= 1'b0;
            r_rise_pend <= 1'b0;
          end else begin
            r_rise_pend <= 1'b0;
          end
        end
        LOAD: begin
          if (w_pk_load) begin
            r_pk       <= w_new;
            r_pk_valid <= 1'b1;
          end else if (w_pk_clear) begin
            r_pk_valid <= 1'b0;
          end
          if (w_drop) begin
            r_dl_ovf <= 1'b1;
          end
          if (!i_dl_active) begin
            r_state <= FLUSH;
          end
        end
        FLUSH: begin
          if (w_pk_clear) begin
            r_pk_valid <= 1'b0;
          end
          if (w_act_rise) begin
            r_rise_pend <= 1'b1;
          end
          if (!r_pk_valid && w_empty && w_port_idle) begin
            r_state   <= DONE;
            r_dl_done <= 1'b1;
          end
        end
        DONE: begin
          if (w_act_rise) begin
            r_rise_pend <= 1'b1;
          end
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  // Request issue: latch the FIFO head and toggle req when the port is idle.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_port_req <= 1'b0;
      r_port_a   <= '0;
      r_port_ds  <= '0;
      r_port_d   <= '0;
    end else if (w_issue) begin
      r_port_req <= ~r_port_req;
      r_port_a   <= w_head.a;
      r_port_ds  <= w_head.ds;
      r_port_d   <= w_head.d;
    end
  end

  // Backpressure: registered, leaving one slot for a strobe already in flight.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_dl_wait <= 1'b0;
    end else begin
      r_dl_wait <= (w_count >= WAIT_LVL) || (r_state == FLUSH);
    end
  end

  assign o_dl_wait  = r_dl_wait;
  assign o_port_req = r_port_req;
  assign o_port_we  = 1'b1;
  assign o_port_a   = r_port_a;
  assign o_port_ds  = r_port_ds;
  assign o_port_d   = r_port_d;
  assign o_dl_done  = r_dl_done;
  assign o_dl_ovf   = r_dl_ovf;

endmodule

// File: tb/tb_rom_dl_bridge.sv
// Directed bench for rom_dl_bridge with a toggle-handshake controller model
// that acknowledges three cycles after each request toggle.
module tb_rom_dl_bridge;

  logic        clk = 1'b0;
  logic        reset;
  logic        dl_active;
  logic        dl_wr;
  logic [23:0] dl_addr;
  logic [7:0]  dl_data;
  logic        dl_wait;
  logic        port_req;
  logic        port_ack;
  logic        port_we;
  logic [22:0] port_a;
  logic [1:0]  port_ds;
  logic [15:0] port_d;
  logic        dl_done;
  logic        dl_ovf;

  int          checks = 0;
  int          errors = 0;
  int          done_cnt = 0;
  logic        ack_en = 1'b1;
  int          ack_cnt = 0;
  logic        prev_req = 1'b0;
  logic [40:0] req_q [$];

  always #5 clk = ~clk;

  rom_dl_bridge #(.FIFO_DEPTH(4)) dut (
    .i_clk       (clk),
    .i_reset     (reset),
    .i_dl_active (dl_active),
    .i_dl_wr     (dl_wr),
    .i_dl_addr   (dl_addr),
    .i_dl_data   (dl_data),
    .o_dl_wait   (dl_wait),
    .o_port_req  (port_req),
    .i_port_ack  (port_ack),
    .o_port_we   (port_we),
    .o_port_a    (port_a),
    .o_port_ds   (port_ds),
    .o_port_d    (port_d),
    .o_dl_done   (dl_done),
    .o_dl_ovf    (dl_ovf)
  );

  // Controller model: ack follows req three cycles after each toggle.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      port_ack <= 1'b0;
      ack_cnt  <= 0;
    end else if (ack_en && (port_req != port_ack)) begin
      if (ack_cnt == 2) begin
        port_ack <= port_req;
        ack_cnt  <= 0;
      end else begin
        ack_cnt <= ack_cnt + 1;
      end
    end
  end

  // Record every issued request and count done pulses.
  always @(negedge clk) begin
    if (reset) begin
      prev_req <= 1'b0;
    end else begin
      if (port_req !== prev_req) req_q.push_back({port_a, port_ds, port_d});
      prev_req <= port_req;
      if (dl_done) done_cnt <= done_cnt + 1;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_req(input string tag, input int idx, input logic [40:0] exp);
    logic [40:0] got;
    got = (idx < req_q.size()) ? req_q[idx] : 41'h1FF_FFFF_FFFF;
    check(tag, {23'h0, got}, {23'h0, exp});
  endtask

  task automatic send_byte(input logic [23:0] a, input logic [7:0] d);
    dl_wr   = 1'b1;
    dl_addr = a;
    dl_data = d;
    @(negedge clk);
    dl_wr   = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int base);
    int n;
    n = 0;
    while (done_cnt == base && n < 600) begin
      @(negedge clk);
      n++;
    end
    check(tag, {63'h0, (done_cnt != base)}, 64'h1);
    repeat (4) @(negedge clk);
  endtask

  int base;
  int sent;
  logic wait_seen;

  initial begin
    reset = 1'b1; dl_active = 1'b0; dl_wr = 1'b0; dl_addr = 24'h0; dl_data = 8'h0;
    repeat (3) @(negedge clk);
    check("rst_req",  {63'h0, port_req}, 64'h0);
    check("rst_a",    {41'h0, port_a}, 64'h0);
    check("rst_ds",   {62'h0, port_ds}, 64'h0);
    check("rst_d",    {48'h0, port_d}, 64'h0);
    check("rst_wait", {63'h0, dl_wait}, 64'h0);
    check("rst_done", {63'h0, dl_done}, 64'h0);
    check("rst_ovf",  {63'h0, dl_ovf}, 64'h0);
    check("port_we",  {63'h0, port_we}, 64'h1);
    reset = 1'b0;
    @(negedge clk);

    // Sequential stream 0..3
    req_q.delete(); base = done_cnt;
    dl_active = 1'b1;
    @(negedge clk);
    send_byte(24'h000000, 8'h11);
    send_byte(24'h000001, 8'h22);
    check("seq_lat_pre", {63'h0, port_req}, 64'h0);
    send_byte(24'h000002, 8'h33);
    check("seq_lat_req", {63'h0, port_req}, 64'h1);
    check("seq_lat_d",   {48'h0, port_d}, 64'h2211);
    send_byte(24'h000003, 8'h44);
    dl_active = 1'b0;
    repeat (2) @(negedge clk);
    check("seq_flush_wait", {63'h0, dl_wait}, 64'h1);
    wait_done("seq_done", base);
    check("seq_nreq", req_q.size(), 64'd2);
    check_req("seq_w0", 0, {23'h0, 2'b11, 16'h2211});
    check_req("seq_w1", 1, {23'h1, 2'b11, 16'h4433});
    check("seq_done_once", done_cnt - base, 64'd1);
    check("seq_wait_idle", {63'h0, dl_wait}, 64'h0);

    // Odd start, odd length
    req_q.delete(); base = done_cnt;
    dl_active = 1'b1;
    @(negedge clk);
    send_byte(24'h000005, 8'hAA);
    send_byte(24'h000006, 8'hBB);
    send_byte(24'h000007, 8'hCC);
    dl_active = 1'b0;
    wait_done("odd_done", base);
    check("odd_nreq", req_q.size(), 64'd2);
    check_req("odd_w0", 0, {23'h2, 2'b10, 16'hAA00});
    check_req("odd_w1", 1, {23'h3, 2'b11, 16'hCCBB});
    check("odd_done_once", done_cnt - base, 64'd1);

    // Backpressure: acks withheld, downloader obeys dl_wait
    req_q.delete(); base = done_cnt;
    ack_en = 1'b0;
    dl_active = 1'b1;
    @(negedge clk);
    sent = 0; wait_seen = 1'b0;
    for (int c = 0; c < 60; c++) begin
      if (dl_wait) wait_seen = 1'b1;
      if (!dl_wait && sent < 16) begin
        dl_wr = 1'b1; dl_addr = 24'(32'h100 + sent); dl_data = 8'(32'hA0 + sent); sent++;
      end else begin
        dl_wr = 1'b0;
      end
      @(negedge clk);
    end
    dl_wr = 1'b0;
    check("bp_wait_seen", {63'h0, wait_seen}, 64'h1);
    check("bp_sent_hold", sent, 64'd9);
    check("bp_ovf_hold", {63'h0, dl_ovf}, 64'h0);
    ack_en = 1'b1;
    for (int c = 0; c < 400 && sent < 16; c++) begin
      if (!dl_wait) begin
        dl_wr = 1'b1; dl_addr = 24'(32'h100 + sent); dl_data = 8'(32'hA0 + sent); sent++;
      end else begin
        dl_wr = 1'b0;
      end
      @(negedge clk);
    end
    dl_wr = 1'b0;
    check("bp_sent_all", sent, 64'd16);
    dl_active = 1'b0;
    wait_done("bp_done", base);
    check("bp_nreq", req_q.size(), 64'd8);
    for (int k = 0; k < 8; k++) begin
      check_req("bp_word", k, {23'(32'h80 + k), 2'b11, 8'(32'hA1 + 2*k), 8'(32'hA0 + 2*k)});
    end
    check("bp_ovf", {63'h0, dl_ovf}, 64'h0);

    // Forced overflow: dl_wait ignored, no acks
    req_q.delete(); base = done_cnt;
    ack_en = 1'b0;
    dl_active = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 13; i++) begin
      send_byte(24'(32'h200 + i), 8'(32'hC0 + i));
    end
    check("ovf_set", {63'h0, dl_ovf}, 64'h1);
    ack_en = 1'b1;
    dl_active = 1'b0;
    wait_done("ovf_done", base);
    check("ovf_sticky", {63'h0, dl_ovf}, 64'h1);
    check("ovf_nreq", req_q.size(), 64'd6);
    check_req("ovf_w0", 0, {23'h100, 2'b11, 16'hC1C0});
    check_req("ovf_w1", 1, {23'h101, 2'b11, 16'hC3C2});
    check_req("ovf_w2", 2, {23'h102, 2'b11, 16'hC5C4});
    check_req("ovf_w3", 3, {23'h103, 2'b11, 16'hC7C6});
    check_req("ovf_w4", 4, {23'h104, 2'b11, 16'hC9C8});
    check_req("ovf_w5", 5, {23'h105, 2'b01, 16'h00CA});
    base = done_cnt;
    dl_active = 1'b1;
    repeat (2) @(negedge clk);
    check("ovf_cleared", {63'h0, dl_ovf}, 64'h0);
    dl_active = 1'b0;
    wait_done("empty_done", base);

    // Reset while a request is outstanding
    ack_en = 1'b0;
    dl_active = 1'b1;
    @(negedge clk);
    send_byte(24'h000300, 8'h01);
    send_byte(24'h000301, 8'h02);
    @(negedge clk);
    check("mid_req", {63'h0, port_req}, 64'h1);
    check("mid_a", {41'h0, port_a}, 64'h180);
    reset = 1'b1;
    dl_active = 1'b0;
    #1;
    check("mrst_req",  {63'h0, port_req}, 64'h0);
    check("mrst_a",    {41'h0, port_a}, 64'h0);
    check("mrst_ds",   {62'h0, port_ds}, 64'h0);
    check("mrst_d",    {48'h0, port_d}, 64'h0);
    check("mrst_wait", {63'h0, dl_wait}, 64'h0);
    check("mrst_done", {63'h0, dl_done}, 64'h0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    ack_en = 1'b1;
    @(negedge clk);
    req_q.delete(); base = done_cnt;
    dl_active = 1'b1;
    @(negedge clk);
    send_byte(24'h000040, 8'h5A);
    send_byte(24'h000041, 8'hA5);
    dl_active = 1'b0;
    wait_done("fresh_done", base);
    check("fresh_nreq", req_q.size(), 64'd1);
    check_req("fresh_w0", 0, {23'h20, 2'b11, 16'hA55A});
    check("fresh_done_once", done_cnt - base, 64'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
